// File: rtl/cgra_pkg.sv
// Shared types and constants for the CGRA tile's arithmetic sequencers.
package cgra_pkg;
  localparam int DEFAULT_WORD_WIDTH = 16;

  typedef enum logic [1:0] {
    IDLE,
    RUN,
    DRAIN,
    DONE
  } add_seq_state_t;
endpackage

// File: rtl/full_adder.sv
// Combinational WIDTH-bit adder with enable, carry gating and acknowledge.
// Outputs are forced to zero whenever the adder is off or held in reset.
module full_adder
  import cgra_pkg::*;
#(
  parameter int WIDTH = DEFAULT_WORD_WIDTH
) (
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             carry_in,
  input  logic             carry_listen,
  input  logic             on_off,
  input  logic             reset,
  output logic [WIDTH-1:0] c,
  output logic             carry_out,
  output logic             ack
);

  always_comb begin
    c         = '0;
    carry_out = 1'b0;
    ack       = 1'b0;
    if (on_off && !reset) begin
      {carry_out, c} = {1'b0, a} + {1'b0, b} + {{WIDTH{1'b0}}, carry_listen & carry_in};
      ack            = 1'b1;
    end
  end

endmodule

// File: rtl/multiword_add_sequencer.sv
// Multi-precision adder: streams LS-first operand words through one full_adder,
// chaining carry in a register; one registered output stage with valid/ready.
module multiword_add_sequencer
  import cgra_pkg::*;
#(
  parameter int WIDTH     = DEFAULT_WORD_WIDTH,
  parameter int MAX_WORDS = 8,
  localparam int CNT_W    = $clog2(MAX_WORDS + 1)
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             start,
  input  logic [CNT_W-1:0] num_words,
  input  logic             carry_seed,
  output logic             busy,
  output logic             err,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] a_word,
  input  logic [WIDTH-1:0] b_word,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] sum_word,
  output logic             last,
  output logic             carry_final,
  output logic             done
);

  localparam logic [CNT_W-1:0] MAX_CNT = CNT_W'(MAX_WORDS);

  add_seq_state_t   r_state;
  add_seq_state_t   w_next;
  logic [CNT_W-1:0] r_num_words;
  logic [CNT_W-1:0] r_word_cnt;
  logic             r_carry;
  logic [WIDTH-1:0] r_sum;
  logic             r_out_valid;
  logic             r_last;
  logic             r_carry_final;
  logic             r_busy;
  logic             r_err;

  logic             w_start_ok;
  logic             w_in_rdy;
  logic             w_in_hs;
  logic             w_out_hs;
  logic             w_last_word;
  logic [WIDTH-1:0] w_c;
  logic             w_cout;

  assign w_start_ok  = (num_words != '0) && (num_words <= MAX_CNT);
  assign w_out_hs    = r_out_valid && out_ready;
  assign w_last_word = (r_word_cnt == r_num_words - 1'b1);

  full_adder #(.WIDTH(WIDTH)) u_full_adder (
    .a            (a_word),
    .b            (b_word),
    .carry_in     (r_carry),
    .carry_listen (1'b1),
    .on_off       (w_in_hs),
    .reset        (reset),
    .c            (w_c),
    .carry_out    (w_cout),
    .ack          ()
  );

  always_ff @(posedge clk) begin
    if (reset) r_state <= IDLE;
    else       r_state <= w_next;
  end

  always_comb begin
    w_next   = r_state;
    w_in_rdy = 1'b0;
    case (r_state)
      IDLE:    if (start && w_start_ok) w_next = RUN;
      RUN: begin
        // Single output register: a new word may enter as the old one leaves.
        w_in_rdy = !r_out_valid || out_ready;
        if (in_valid && w_in_rdy && w_last_word) w_next = DRAIN;
      end
      DRAIN:   if (w_out_hs) w_next = DONE;
      DONE:    w_next = IDLE;
      default: w_next = IDLE;
    endcase
    w_in_hs = in_valid && w_in_rdy;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      r_num_words   <= '0;
      r_word_cnt    <= '0;
      r_carry       <= 1'b0;
      r_sum         <= '0;
      r_out_valid   <= 1'b0;
      r_last        <= 1'b0;
      r_carry_final <= 1'b0;
      r_busy        <= 1'b0;
      r_err         <= 1'b0;
    end else begin
      r_err <= 1'b0;
      case (r_state)
        IDLE: begin
          if (start && w_start_ok) begin
            r_num_words   <= num_words;
            r_word_cnt    <= '0;
            r_carry       <= carry_seed;
            r_carry_final <= 1'b0;
            r_busy        <= 1'b1;
          end else if (start) begin
            r_err <= 1'b1;
          end
        end
        RUN: begin
          if (w_in_hs) begin
            r_sum       <= w_c;
            r_carry     <= w_cout;
            r_out_valid <= 1'b1;
            r_word_cnt  <= r_word_cnt + 1'b1;
            r_last      <= w_last_word;
            if (w_last_word) r_carry_final <= w_cout;
          end else if (w_out_hs) begin
            r_out_valid <= 1'b0;
          end
        end
        DRAIN: begin
          if (w_out_hs) begin
            r_out_valid <= 1'b0;
            r_last      <= 1'b0;
          end
        end
        DONE:    r_busy <= 1'b0;
        default: r_busy <= 1'b0;
      endcase
    end
  end

  assign busy        = r_busy;
  assign err         = r_err;
  assign in_ready    = w_in_rdy;
  assign out_valid   = r_out_valid;
  assign sum_word    = r_sum;
  assign last        = r_last;
  assign carry_final = r_carry_final;
  assign done        = (r_state == DONE);

endmodule

// File: tb/tb_multiword_add_sequencer.sv
// Bench for multiword_add_sequencer: directed scenarios plus random jobs
// checked against a wide-integer model of the multi-precision sum.
module tb_multiword_add_sequencer;
  localparam int WIDTH = 16;
  localparam int CNT_W = 4;

  logic             clk = 1'b0;
  logic             reset, start, carry_seed, in_valid, out_ready;
  logic [CNT_W-1:0] num_words;
  logic [WIDTH-1:0] a_word, b_word;
  logic             busy, err, in_ready, out_valid, last, carry_final, done;
  logic [WIDTH-1:0] sum_word;

  multiword_add_sequencer dut (
    .clk(clk), .reset(reset), .start(start), .num_words(num_words),
    .carry_seed(carry_seed), .busy(busy), .err(err), .in_valid(in_valid),
    .in_ready(in_ready), .a_word(a_word), .b_word(b_word),
    .out_valid(out_valid), .out_ready(out_ready), .sum_word(sum_word),
    .last(last), .carry_final(carry_final), .done(done)
  );

  always #5 clk = ~clk;

  int total = 0;
  int bad   = 0;

  logic [15:0] job_a[8];
  logic [15:0] job_b[8];
  logic [15:0] exp_w[8];
  logic        exp_c;

  logic [15:0] got_w[$];
  logic        got_l[$];
  int          last_cyc, done_cyc, first_in_cyc, first_ov_cyc;
  int          max_streak, stab_viol, rdy_viol, done_pulses;
  logic        timed_out, busy_start, busy_at_done, busy_after;

  // Reference: the job is one (16*n)-bit addition; sum words and carry are slices.
  task automatic model(input int n, input logic seed);
    logic [128:0] sa, sb, s;
    sa = '0;
    sb = '0;
    for (int i = 0; i < n; i++) begin
      sa[16*i +: 16] = job_a[i];
      sb[16*i +: 16] = job_b[i];
    end
    s = sa + sb + 129'(seed);
    for (int i = 0; i < 8; i++) exp_w[i] = s[16*i +: 16];
    exp_c = s[16*n];
  endtask

  // mode 0: out_ready always high; 1: random; 2: low for 4 cycles at first sum
  task automatic run_job(input int n, input logic seed, input int in_pct, input int mode);
    int   idx, streak, bp_left;
    logic bp_used, prev_hold, prev_l;
    logic [15:0] prev_w;
    idx = 0; streak = 0; bp_left = 0; bp_used = 0; prev_hold = 0; prev_l = 0; prev_w = '0;
    got_w.delete(); got_l.delete();
    last_cyc = -1; done_cyc = -1; first_in_cyc = -1; first_ov_cyc = -1;
    max_streak = 0; stab_viol = 0; rdy_viol = 0; done_pulses = 0;
    timed_out = 0; busy_at_done = 0; busy_after = 1;
    @(negedge clk);
    start = 1; num_words = CNT_W'(n); carry_seed = seed; in_valid = 0;
    @(negedge clk);
    start = 0;
    busy_start = busy;
    for (int cyc = 0; cyc < 300; cyc++) begin
      if (cyc > 0) @(negedge clk);
      case (mode)
        0: out_ready = 1;
        1: out_ready = (int'($urandom_range(99)) < 60);
        default: begin
          if (bp_left > 0) begin
            out_ready = 0; bp_left--;
          end else if (out_valid && !bp_used) begin
            bp_used = 1; out_ready = 0; bp_left = 3;
          end else out_ready = 1;
        end
      endcase
      in_valid = (idx < n) && (in_pct >= 100 || int'($urandom_range(99)) < in_pct);
      a_word   = (idx < n) ? job_a[idx] : 16'($urandom);
      b_word   = (idx < n) ? job_b[idx] : 16'($urandom);
      #1;
      if (prev_hold && (sum_word !== prev_w || last !== prev_l)) stab_viol++;
      if (out_valid && !out_ready && in_ready) rdy_viol++;
      streak = in_ready ? streak + 1 : 0;
      if (streak > max_streak) max_streak = streak;
      if (out_valid && first_ov_cyc < 0) first_ov_cyc = cyc;
      if (done) begin
        done_pulses++;
        if (done_cyc < 0) begin done_cyc = cyc; busy_at_done = busy; end
      end
      if (done_cyc >= 0 && cyc == done_cyc + 1) busy_after = busy;
      if (in_valid && in_ready) begin
        if (first_in_cyc < 0) first_in_cyc = cyc;
        idx++;
      end
      if (out_valid && out_ready) begin
        got_w.push_back(sum_word);
        got_l.push_back(last);
        if (last) last_cyc = cyc;
      end
      prev_hold = out_valid && !out_ready;
      prev_w = sum_word;
      prev_l = last;
      if (done_cyc >= 0 && cyc >= done_cyc + 2) break;
    end
    in_valid = 0;
    if (done_cyc < 0) timed_out = 1;
  endtask

  task automatic test_reset;
    reset = 1; start = 0; num_words = '0; carry_seed = 0;
    in_valid = 0; out_ready = 0; a_word = '0; b_word = '0;
    repeat (2) @(negedge clk);
    total++;
    if ({busy, err, in_ready, out_valid, sum_word, last, carry_final, done} !== 23'd0) begin
      bad++; $display("FAIL reset_outputs got=%h want=0",
        {busy, err, in_ready, out_valid, sum_word, last, carry_final, done});
    end
    reset = 0; in_valid = 1;
    @(negedge clk);
    total++;
    if (in_ready !== 1'b0 || busy !== 1'b0) begin
      bad++; $display("FAIL idle_in_ready got=%b/%b want=0/0", in_ready, busy);
    end
    in_valid = 0;
  endtask

  task automatic test_two_word;
    job_a[0] = 16'hFFFF; job_a[1] = 16'h0001;
    job_b[0] = 16'h0001; job_b[1] = 16'h0000;
    run_job(2, 0, 100, 0);
    total++;
    if (timed_out || got_w.size() != 2) begin
      bad++; $display("FAIL two_count got=%0d want=2", got_w.size());
    end
    total++;
    if (got_w[0] !== 16'h0000 || got_w[1] !== 16'h0002) begin
      bad++; $display("FAIL two_sums got=%h,%h want=0000,0002", got_w[0], got_w[1]);
    end
    total++;
    if (got_l[0] !== 1'b0 || got_l[1] !== 1'b1) begin
      bad++; $display("FAIL two_last got=%b%b want=01", got_l[0], got_l[1]);
    end
    total++;
    if (carry_final !== 1'b0) begin
      bad++; $display("FAIL two_carry got=%b want=0", carry_final);
    end
    total++;
    if (first_ov_cyc != first_in_cyc + 1) begin
      bad++; $display("FAIL two_latency got=%0d want=%0d", first_ov_cyc, first_in_cyc + 1);
    end
    total++;
    if (done_cyc != last_cyc + 1 || done_pulses != 1) begin
      bad++; $display("FAIL two_done got=%0d/%0d want=%0d/1", done_cyc, done_pulses, last_cyc + 1);
    end
    total++;
    if ({busy_start, busy_at_done, busy_after} !== 3'b110) begin
      bad++; $display("FAIL two_busy got=%b want=110", {busy_start, busy_at_done, busy_after});
    end
  endtask

  task automatic test_eight_word;
    for (int i = 0; i < 8; i++) begin
      job_a[i] = 16'hFFFF;
      job_b[i] = (i == 0) ? 16'h0001 : 16'h0000;
    end
    run_job(8, 0, 100, 0);
    for (int i = 0; i < 8; i++) begin
      total++;
      if (got_w[i] !== 16'h0000) begin
        bad++; $display("FAIL eight_sum%0d got=%h want=0000", i, got_w[i]);
      end
    end
    total++;
    if (timed_out || carry_final !== 1'b1) begin
      bad++; $display("FAIL eight_carry got=%b want=1", carry_final);
    end
    total++;
    if (max_streak != 8) begin
      bad++; $display("FAIL eight_in_ready_run got=%0d want=8", max_streak);
    end
  endtask

  task automatic test_subtract;
    job_a[0] = 16'h1234;
    job_b[0] = 16'hEDCB;
    run_job(1, 1, 100, 0);
    total++;
    if (timed_out || got_w.size() != 1 || got_w[0] !== 16'h0000 || got_l[0] !== 1'b1) begin
      bad++; $display("FAIL sub_sum got=%h last=%b want=0000 last=1", got_w[0], got_l[0]);
    end
    total++;
    if (carry_final !== 1'b1) begin
      bad++; $display("FAIL sub_carry got=%b want=1", carry_final);
    end
  endtask

  task automatic test_backpressure;
    for (int i = 0; i < 3; i++) begin
      job_a[i] = 16'($urandom);
      job_b[i] = 16'($urandom);
    end
    model(3, 0);
    run_job(3, 0, 100, 2);
    total++;
    if (stab_viol != 0 || rdy_viol != 0) begin
      bad++; $display("FAIL bp_hold got=%0d/%0d want=0/0", stab_viol, rdy_viol);
    end
    for (int i = 0; i < 3; i++) begin
      total++;
      if (got_w[i] !== exp_w[i]) begin
        bad++; $display("FAIL bp_sum%0d got=%h want=%h", i, got_w[i], exp_w[i]);
      end
    end
    total++;
    if (timed_out || carry_final !== exp_c) begin
      bad++; $display("FAIL bp_carry got=%b want=%b", carry_final, exp_c);
    end
  endtask

  task automatic test_reject;
    logic [CNT_W-1:0] bad_n[2];
    bad_n[0] = 4'd0;
    bad_n[1] = 4'd9;
    for (int k = 0; k < 2; k++) begin
      @(negedge clk);
      start = 1; num_words = bad_n[k];
      @(negedge clk);
      start = 0;
      total++;
      if (err !== 1'b1 || busy !== 1'b0) begin
        bad++; $display("FAIL reject%0d_err got=%b/%b want=1/0", bad_n[k], err, busy);
      end
      @(negedge clk);
      total++;
      if (err !== 1'b0 || busy !== 1'b0 || in_ready !== 1'b0) begin
        bad++; $display("FAIL reject%0d_after got=%b%b%b want=000", bad_n[k], err, busy, in_ready);
      end
    end
    job_a[0] = 16'($urandom);
    job_b[0] = 16'($urandom);
    model(1, 0);
    run_job(1, 0, 100, 0);
    total++;
    if (timed_out || got_w[0] !== exp_w[0] || carry_final !== exp_c) begin
      bad++; $display("FAIL reject_then_job got=%h/%b want=%h/%b", got_w[0], carry_final, exp_w[0], exp_c);
    end
  endtask

  task automatic test_reset_mid_job;
    int done_seen;
    done_seen = 0;
    @(negedge clk);
    start = 1; num_words = 4'd4; carry_seed = 0;
    @(negedge clk);
    start = 0; out_ready = 1; in_valid = 1; a_word = 16'h1111; b_word = 16'h2222;
    @(negedge clk);
    a_word = 16'h3333; b_word = 16'h4444;
    @(negedge clk);
    in_valid = 0; reset = 1;
    @(negedge clk);
    total++;
    if ({busy, err, in_ready, out_valid, sum_word, last, carry_final, done} !== 23'd0) begin
      bad++; $display("FAIL midreset_outputs got=%h want=0",
        {busy, err, in_ready, out_valid, sum_word, last, carry_final, done});
    end
    reset = 0;
    repeat (6) begin
      @(negedge clk);
      if (done || busy) done_seen++;
    end
    total++;
    if (done_seen != 0) begin
      bad++; $display("FAIL midreset_no_done got=%0d want=0", done_seen);
    end
    for (int i = 0; i < 4; i++) begin
      job_a[i] = 16'($urandom);
      job_b[i] = 16'($urandom);
    end
    model(4, 1);
    run_job(4, 1, 100, 0);
    for (int i = 0; i < 4; i++) begin
      total++;
      if (got_w[i] !== exp_w[i]) begin
        bad++; $display("FAIL midreset_sum%0d got=%h want=%h", i, got_w[i], exp_w[i]);
      end
    end
    total++;
    if (timed_out || carry_final !== exp_c) begin
      bad++; $display("FAIL midreset_carry got=%b want=%b", carry_final, exp_c);
    end
  endtask

  task automatic test_random;
    int   n, pct;
    logic seed;
    for (int j = 0; j < 12; j++) begin
      n    = int'($urandom_range(8, 1));
      seed = 1'($urandom);
      pct  = int'($urandom_range(100, 30));
      for (int i = 0; i < 8; i++) begin
        job_a[i] = (j % 3 == 0) ? 16'hFFFF : 16'($urandom);
        job_b[i] = 16'($urandom);
      end
      model(n, seed);
      run_job(n, seed, pct, 1);
      total++;
      if (timed_out || got_w.size() != n) begin
        bad++; $display("FAIL rand%0d_count got=%0d want=%0d", j, got_w.size(), n);
      end
      for (int i = 0; i < n; i++) begin
        total++;
        if (got_w[i] !== exp_w[i] || got_l[i] !== (i == n - 1)) begin
          bad++; $display("FAIL rand%0d_word%0d got=%h/%b want=%h/%b",
            j, i, got_w[i], got_l[i], exp_w[i], (i == n - 1));
        end
      end
      total++;
      if (carry_final !== exp_c || done_cyc != last_cyc + 1 || stab_viol != 0 || rdy_viol != 0) begin
        bad++; $display("FAIL rand%0d_end got=%b/%0d/%0d/%0d want=%b/%0d/0/0",
          j, carry_final, done_cyc, stab_viol, rdy_viol, exp_c, last_cyc + 1);
      end
    end
  endtask

  initial begin
    test_reset();
    test_two_word();
    test_eight_word();
    test_subtract();
    test_backpressure();
    test_reject();
    test_reset_mid_job();
    test_random();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
